// File: rtl/usbbootrom_reader.sv
// usbbootrom_reader: bus-side read front end for the USB boot ROM macro.
//
// Takes word-aligned single or burst read requests on a valid/ready channel,
// drives the ROM me/address pins and captures the registered rom_q one cycle
// later. Beats are returned in order through a 2-entry FIFO. Issue is
// credit-gated, so a stalled consumer never causes a ROM read to be lost.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   req_valid/req_ready request handshake (ready only while idle)
//   req_addr            byte address of the first beat (AW+2 bits)
//   req_len             beats minus one (0..15)
//   resp_valid/ready    response handshake
//   resp_data           read data, 0 on error beats
//   resp_error          beat misaligned or out of range
//   resp_last           final beat of the burst
//   rom_me, rom_oe      ROM read enable / output enable
//   rom_address         ROM word address
//   rom_q               ROM data, valid the cycle after rom_me

module usbbootrom_reader #(
    parameter int DEPTH = 73728,
    parameter int AW    = 17
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW+1:0] req_addr,
    input  logic [3:0]    req_len,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [31:0]   resp_data,
    output logic          resp_error,
    output logic          resp_last,
    output logic          rom_me,
    output logic          rom_oe,
    output logic [AW-1:0] rom_address,
    input  logic [31:0]   rom_q
);

    // Word index is one bit wider than the ROM address so that a burst
    // running past the end keeps counting upward instead of wrapping.
    localparam logic [AW:0] LIMIT = (AW+1)'(DEPTH);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [AW:0] idx;
    logic [AW:0] idx_nx;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nx;
    logic        mis;
    logic        mis_nx;

    logic        inflight;
    logic        inf_err;
    logic        inf_last;

    logic [31:0] f_data [2];
    logic        f_err  [2];
    logic        f_last [2];
    logic        wptr;
    logic        rptr;
    logic [1:0]  fcount;

    logic        push;
    logic        pop;
    logic [2:0]  occ;
    logic        credit;
    logic        issue;
    logic        bad;

    assign push = inflight;
    assign pop  = resp_valid & resp_ready;

    // Occupancy once this cycle's push/pop settle; a new issue is only
    // allowed if it still leaves room for its beat next cycle.
    assign occ    = 3'(fcount) + 3'(inflight) - 3'(pop);
    assign credit = occ < 3'd2;
    assign issue  = (state == BURST) & credit;
    assign bad    = mis | (idx >= LIMIT);

    assign rom_me      = issue & ~bad;
    assign rom_address = rom_me ? idx[AW-1:0] : '0;
    assign rom_oe      = ~reset;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
            cnt   <= '0;
            mis   <= 1'b0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            cnt   <= cnt_nx;
            mis   <= mis_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        idx_nx    = idx;
        cnt_nx    = cnt;
        mis_nx    = mis;
        req_ready = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    idx_nx   = {1'b0, req_addr[AW+1:2]};
                    cnt_nx   = req_len;
                    mis_nx   = |req_addr[1:0];
                    state_nx = BURST;
                end
            end
            BURST: begin
                if (issue) begin
                    idx_nx = idx + 1'b1;
                    cnt_nx = cnt - 4'd1;
                    if (cnt == 4'd0) begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // One-deep tag pipeline that lines up with the ROM's registered output.
    always_ff @(posedge clock) begin
        if (reset) begin
            inflight <= 1'b0;
            inf_err  <= 1'b0;
            inf_last <= 1'b0;
        end else begin
            inflight <= issue;
            inf_err  <= bad;
            inf_last <= (cnt == 4'd0);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr   <= 1'b0;
            rptr   <= 1'b0;
            fcount <= 2'd0;
        end else begin
            if (push) begin
                wptr <= ~wptr;
            end
            if (pop) begin
                rptr <= ~rptr;
            end
            fcount <= fcount + 2'(push) - 2'(pop);
        end
    end

    // Storage needs no reset: outputs are masked while the FIFO is empty.
    always_ff @(posedge clock) begin
        if (push) begin
            f_data[wptr] <= inf_err ? 32'd0 : rom_q;
            f_err[wptr]  <= inf_err;
            f_last[wptr] <= inf_last;
        end
    end

    assign resp_valid = (fcount != 2'd0);
    assign resp_data  = resp_valid ? f_data[rptr] : 32'd0;
    assign resp_error = resp_valid & f_err[rptr];
    assign resp_last  = resp_valid & f_last[rptr];

endmodule

// File: tb/tb_usbbootrom_reader.sv
// tb_usbbootrom_reader: scoreboard bench for usbbootrom_reader.
// Directed requests push expected beats; a negedge monitor pops and checks.

module tb_usbbootrom_reader;

    localparam int DEPTH = 73728;
    localparam int AW    = 17;

    logic          clock;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [AW+1:0] req_addr;
    logic [3:0]    req_len;
    logic          resp_valid;
    logic          resp_ready;
    logic [31:0]   resp_data;
    logic          resp_error;
    logic          resp_last;
    logic          rom_me;
    logic          rom_oe;
    logic [AW-1:0] rom_address;
    logic [31:0]   rom_q;

    usbbootrom_reader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_len     (req_len),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_data   (resp_data),
        .resp_error  (resp_error),
        .resp_last   (resp_last),
        .rom_me      (rom_me),
        .rom_oe      (rom_oe),
        .rom_address (rom_address),
        .rom_q       (rom_q)
    );

    typedef struct packed {
        logic [31:0] d;
        logic        e;
        logic        l;
    } beat_t;

    beat_t sb[$];
    int    aq[$];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int pop_count = 0;
    int last_pop_cyc = 0;
    int me_count = 0;
    int outs = 0;
    bit chk_credit = 0;
    bit toggling = 0;

    bit          hold_prev = 0;
    logic [31:0] prev_d;
    logic        prev_e;
    logic        prev_l;
    beat_t       mb;

    initial clock = 0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [31:0] romword(input int a);
        if (a == 4) return 32'hDEADBEEF;
        return 32'h5A000000 | 32'(a);
    endfunction

    always @(posedge clock) begin
        if (rom_me) rom_q <= romword(int'(rom_address));
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (hold_prev) begin
                chk("hold_valid", 32'(resp_valid), 32'd1);
                chk("hold_data", resp_data, prev_d);
                chk("hold_error", 32'(resp_error), 32'(prev_e));
                chk("hold_last", 32'(resp_last), 32'(prev_l));
            end
            if (resp_valid && resp_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat", 32'd1, 32'd0);
                end else begin
                    mb = sb.pop_front();
                    chk("resp_data", resp_data, mb.d);
                    chk("resp_error", 32'(resp_error), 32'(mb.e));
                    chk("resp_last", 32'(resp_last), 32'(mb.l));
                end
                pop_count++;
                last_pop_cyc = cyc;
            end
            hold_prev = resp_valid && !resp_ready;
            prev_d = resp_data;
            prev_e = resp_error;
            prev_l = resp_last;
            if (rom_me) begin
                me_count++;
                if (aq.size() == 0)
                    chk("unexpected_rom_me", 32'd1, 32'd0);
                else
                    chk("rom_address", 32'(rom_address), 32'(aq.pop_front()));
            end
            outs = outs - int'(resp_valid && resp_ready) + int'(rom_me);
            if (chk_credit)
                chk("outstanding_le_2", 32'(outs <= 2), 32'd1);
        end else begin
            hold_prev = 0;
            outs = 0;
        end
    end

    task automatic issue_req(input logic [AW+1:0] addr, input logic [3:0] len,
                             output int acc);
        int  w;
        int  t;
        bit  m;
        int  ix;
        beat_t b;
        w = int'(addr[AW+1:2]);
        m = |addr[1:0];
        for (int i = 0; i <= int'(len); i++) begin
            ix  = w + i;
            b.l = (i == int'(len));
            if (m || ix >= DEPTH) begin
                b.d = 32'd0;
                b.e = 1'b1;
            end else begin
                b.d = romword(ix);
                b.e = 1'b0;
                aq.push_back(ix);
            end
            sb.push_back(b);
        end
        t = 0;
        while (!req_ready && t < 200) begin
            @(posedge clock);
            #1;
            t++;
        end
        if (t >= 200) chk("req_ready_timeout", 32'd0, 32'd1);
        req_addr  = addr;
        req_len   = len;
        req_valid = 1'b1;
        acc = cyc;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 2000) begin
            @(posedge clock);
            #1;
            t++;
        end
        chk("drain_left", 32'(sb.size()), 32'd0);
    endtask

    task automatic wait_pops(input int target);
        int t;
        t = 0;
        while (pop_count < target && t < 200) begin
            @(posedge clock);
            #1;
            t++;
        end
        chk("pop_wait", 32'(pop_count >= target), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int acc;
        int base;
        int me0;

        reset      = 1'b1;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_len    = '0;
        resp_ready = 1'b1;
        rom_q      = 32'd0;

        @(posedge clock);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_resp_error", 32'(resp_error), 32'd0);
        chk("rst_resp_last", 32'(resp_last), 32'd0);
        chk("rst_rom_me", 32'(rom_me), 32'd0);
        chk("rst_rom_oe", 32'(rom_oe), 32'd0);
        chk("rst_rom_address", 32'(rom_address), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        chk("rom_oe_run", 32'(rom_oe), 32'd1);

        // single read of word 4
        issue_req(19'h10, 4'd0, acc);
        chk("t1_rom_me_c1", 32'(rom_me), 32'd1);
        chk("t1_addr_c1", 32'(rom_address), 32'd4);
        @(posedge clock);
        #1;
        chk("t1_valid_c2", 32'(resp_valid), 32'd0);
        @(posedge clock);
        #1;
        chk("t1_valid_c3", 32'(resp_valid), 32'd1);
        chk("t1_data_c3", resp_data, 32'hDEADBEEF);
        drain();

        // 16-beat burst, consumer always ready
        base = pop_count;
        me0  = me_count;
        issue_req(19'h0, 4'd15, acc);
        wait_pops(base + 1);
        chk("t2_first_cycle", 32'(last_pop_cyc - acc), 32'd3);
        wait_pops(base + 16);
        chk("t2_last_cycle", 32'(last_pop_cyc - acc), 32'd18);
        drain();
        chk("t2_me_count", 32'(me_count - me0), 32'd16);

        // same burst, consumer toggling
        @(posedge clock);
        #1;
        outs       = 0;
        chk_credit = 1;
        toggling   = 1;
        fork
            begin
                while (toggling) begin
                    @(posedge clock);
                    #1;
                    resp_ready = ~resp_ready;
                end
            end
            begin
                issue_req(19'h0, 4'd15, acc);
                drain();
                toggling = 0;
            end
        join
        chk_credit = 0;
        resp_ready = 1'b1;

        // burst running past the end of the ROM
        me0 = me_count;
        issue_req(19'(294904), 4'd3, acc);
        drain();
        chk("t4_me_count", 32'(me_count - me0), 32'd2);

        // misaligned burst
        me0 = me_count;
        issue_req(19'h2, 4'd1, acc);
        drain();
        chk("t5_me_count", 32'(me_count - me0), 32'd0);

        // reset with the FIFO full
        resp_ready = 1'b0;
        issue_req(19'h0, 4'd15, acc);
        repeat (6) begin
            @(posedge clock);
            #1;
        end
        chk("t6_full_valid", 32'(resp_valid), 32'd1);
        chk("t6_full_no_me", 32'(rom_me), 32'd0);
        reset = 1'b1;
        sb.delete();
        aq.delete();
        @(posedge clock);
        #1;
        chk("t6_resp_valid", 32'(resp_valid), 32'd0);
        chk("t6_req_ready", 32'(req_ready), 32'd1);
        chk("t6_rom_me", 32'(rom_me), 32'd0);
        reset      = 1'b0;
        resp_ready = 1'b1;
        @(posedge clock);
        #1;
        chk("t6_after_valid", 32'(resp_valid), 32'd0);
        base = pop_count;
        issue_req(19'h10, 4'd1, acc);
        drain();
        chk("t6_new_beats", 32'(pop_count - base), 32'd2);

        repeat (3) @(posedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
